// File: rtl/aes_pipe_scheduler.sv
// Front-end scheduler for a fully pipelined, stall-free AES core.
// Two valid/ready requesters are round-robin arbitrated onto the core input.
// A {valid,id} shift register mirrors the core pipeline. Results land in an
// output FIFO. Issue is credit-limited so the FIFO can never overflow.
module aes_pipe_scheduler #(
    parameter int LATENCY    = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [127:0]                 req0_data,
    input  logic [127:0]                 req0_key,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [127:0]                 req1_data,
    input  logic [127:0]                 req1_key,
    output logic [127:0]                 aes_in,
    output logic [127:0]                 aes_key,
    input  logic [127:0]                 aes_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [127:0]                 rsp_data,
    output logic                         rsp_id,
    output logic [$clog2(FIFO_DEPTH):0]  inflight
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                grant0, grant1, issue, can_issue;
    logic                push, pop, fifo_full;
    logic                prefer1_q, prefer1_d;
    logic [LATENCY-1:0]  trk_valid_q, trk_valid_d;
    logic [LATENCY-1:0]  trk_id_q, trk_id_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]         inflight_q, inflight_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [128:0]        rsp_word_q;
    logic [128:0]        fifo_mem [FIFO_DEPTH];

    // Arbitration and issue mux: grant only with a free credit, alternate on contention.
    // The async reset input also gates grants so ready stays low while reset is held.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        aes_in    = '0;
        aes_key   = '0;
        can_issue = (inflight_q < (AW+1)'(FIFO_DEPTH));
        if (reset && can_issue) begin
            if (req0_valid && req1_valid) begin
                grant1 = prefer1_q;
                grant0 = !prefer1_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        issue = grant0 || grant1;
        if (grant0) begin
            aes_in  = req0_data;
            aes_key = req0_key;
        end else if (grant1) begin
            aes_in  = req1_data;
            aes_key = req1_key;
        end
        // After granting 0, requester 1 is preferred next time, and vice versa
        prefer1_d = issue ? grant0 : prefer1_q;
    end

    // Tracker shift, FIFO pointer and credit bookkeeping.
    always_comb begin
        trk_valid_d = {trk_valid_q[LATENCY-2:0], issue};
        trk_id_d    = {trk_id_q[LATENCY-2:0], grant1};
        push        = trk_valid_q[LATENCY-1];
        pop         = rsp_valid_q && rsp_ready;
        fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        // The next head is presentable unless it is the entry being written on this
        // very edge; in that case it appears one cycle later (no write-through bypass).
        rsp_valid_d = (wr_ptr_d != rd_ptr_d) && !(push && (rd_ptr_d == wr_ptr_q));
        inflight_d  = inflight_q + (AW+1)'(issue) - (AW+1)'(pop);
    end

    // Control state and registered response head; cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prefer1_q   <= 1'b0;
            trk_valid_q <= '0;
            trk_id_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= '0;
        end else begin
            prefer1_q   <= prefer1_d;
            trk_valid_q <= trk_valid_d;
            trk_id_q    <= trk_id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            if (rsp_valid_d) begin
                rsp_word_q <= fifo_mem[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // FIFO storage write: core result tagged with its source id.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {trk_id_q[LATENCY-1], aes_out};
        end
    end

    // Credit admission must make a push into a full FIFO without a pop impossible.
    no_overflow: assert property (@(posedge clock) disable iff (!reset)
                                  !(push && fifo_full && !pop));

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_word_q[127:0];
    assign rsp_id     = rsp_word_q[128];
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Self-checking bench: behavioural AES-128 core stub plus a queue/credit
// reference model of arbitration, ordering and response timing.
module tb_aes_pipe_scheduler;
    localparam int LAT = 10;
    localparam int FD  = 16;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0]         req0_data, req0_key, req1_data, req1_key;
    logic [127:0]         aes_in, aes_key, aes_out;
    logic                 rsp_valid, rsp_ready, rsp_id;
    logic [127:0]         rsp_data;
    logic [$clog2(FD):0]  inflight;

    aes_pipe_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_key(req1_key),
        .aes_in(aes_in), .aes_key(aes_key), .aes_out(aes_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .inflight(inflight)
    );

    always #5 clock = ~clock;

    // ---------------- AES-128 reference ----------------
    bit [7:0] sbox [256];

    function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
        bit [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic bit [7:0] rotl8(input bit [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_sbox();
        bit [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row + 4*col] = t[row + 4*((col + row) % 4)];
            if (rnd != 10) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Stall-free core stub: LAT-stage pipeline of AES results.
    logic [127:0] core_pipe [LAT];
    always @(posedge clock) begin
        core_pipe[0] <= aes_enc(aes_in, aes_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign aes_out = core_pipe[LAT-1];

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit           id;
        logic [127:0] res;
        int           ready_at;   // first edge count at which it may be shown
    } exp_t;
    exp_t exp_q[$];
    int   m_credit = 0;
    bit   m_pref1  = 1'b0;

    bit           v0, v1, rr;
    logic [127:0] d0, k0, d1, k1;
    bit           acc0, acc1, obs_valid, obs_id;
    logic [127:0] obs_data;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step();
        bit g0, g1, ev;
        @(negedge clock);
        req0_valid = v0; req0_data = d0; req0_key = k0;
        req1_valid = v1; req1_data = d1; req1_key = k1;
        rsp_ready  = rr;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (m_credit < FD) begin
            if (v0 && v1) begin g1 = m_pref1; g0 = !m_pref1; end
            else begin g0 = v0; g1 = v1; end
        end
        check_val("req0_ready", 128'(req0_ready), 128'(g0));
        check_val("req1_ready", 128'(req1_ready), 128'(g1));
        check_val("inflight", 128'(inflight), 128'(m_credit));
        if (g0 || g1) begin
            check_val("aes_in", aes_in, g0 ? d0 : d1);
            check_val("aes_key", aes_key, g0 ? k0 : k1);
        end
        ev = (exp_q.size() > 0) && (edge_cnt >= exp_q[0].ready_at);
        check_val("rsp_valid", 128'(rsp_valid), 128'(ev));
        if (ev && rsp_valid) begin
            check_val("rsp_data", rsp_data, exp_q[0].res);
            check_val("rsp_id", 128'(rsp_id), 128'(exp_q[0].id));
        end
        obs_valid = rsp_valid; obs_data = rsp_data; obs_id = rsp_id;
        acc0 = req0_ready; acc1 = req1_ready;
        if (g0 || g1) begin
            exp_q.push_back('{g1, aes_enc(g0 ? d0 : d1, g0 ? k0 : k1), edge_cnt + LAT + 2});
            m_credit++;
            m_pref1 = g0;
        end
        if (ev && rr) begin
            void'(exp_q.pop_front());
            m_credit--;
        end
    endtask

    // Assert reset mid-cycle with current inputs held; outputs must clear at once.
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_val("rst_ready0", 128'(req0_ready), 128'(0));
        check_val("rst_ready1", 128'(req1_ready), 128'(0));
        check_val("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_val("rst_rsp_data", rsp_data, 128'(0));
        check_val("rst_rsp_id", 128'(rsp_id), 128'(0));
        check_val("rst_inflight", 128'(inflight), 128'(0));
        check_val("rst_aes_in", aes_in, 128'(0));
        check_val("rst_aes_key", aes_key, 128'(0));
        exp_q.delete();
        m_credit = 0;
        m_pref1  = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt, cnt2, blocks, cyc, t1_issue;
        bit   seen;
        logic [7:0] grant_seq;

        init_sbox();
        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
        d0 = '0; k0 = '0; d1 = '0; k1 = '0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
        v0 = 1'b1; v1 = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        do_reset();

        // T1: known-answer block and minimum latency
        v0 = 1'b1; v1 = 1'b0; rr = 1'b1;
        d0 = 128'h00112233445566778899aabbccddeeff;
        k0 = 128'h000102030405060708090a0b0c0d0e0f;
        step();
        check_val("t1_accept", 128'(acc0), 128'(1));
        t1_issue = edge_cnt + 1;
        v0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (obs_valid) seen = 1'b1;
        end
        check_val("t1_seen", 128'(seen), 128'(1));
        check_val("t1_latency", 128'(edge_cnt - t1_issue), 128'(LAT + 1));
        check_val("t1_data", obs_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_val("t1_id", 128'(obs_id), 128'(0));
        repeat (4) step();

        // T2: contention alternates 0,1,0,1...
        do_reset();
        v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
        d0 = rand128(); k0 = rand128(); d1 = rand128(); k1 = rand128();
        grant_seq = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            grant_seq[i] = acc1;
            if (acc0) begin d0 = rand128(); k0 = rand128(); end
            if (acc1) begin d1 = rand128(); k1 = rand128(); end
        end
        check_val("t2_grants", 128'(grant_seq), 128'(8'hAA));
        v0 = 1'b0; v1 = 1'b0;
        repeat (20) step();

        // T3: backpressure fills exactly FIFO_DEPTH credits
        rr = 1'b0; v0 = 1'b1; v1 = 1'b0;
        d0 = rand128(); k0 = rand128();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (acc0) begin cnt++; d0 = rand128(); k0 = rand128(); end
        end
        check_val("t3_accepts", 128'(cnt), 128'(FD));
        check_val("t3_inflight", 128'(inflight), 128'(FD));
        check_val("t3_ready_low", 128'(req0_ready), 128'(0));

        // T4: drain with refill, pushes and pops overlapping near full
        cnt2 = 0;
        for (int i = 0; i < 60; i++) begin
            rr = (i % 4) != 3;
            step();
            if (acc0) begin cnt2++; d0 = rand128(); k0 = rand128(); end
        end
        check_val("t3_resume", 128'(cnt2 > 0), 128'(1));
        v0 = 1'b0; rr = 1'b1;
        repeat (40) step();
        check_val("t3_drained", 128'(inflight), 128'(0));

        // T5: reset with blocks in flight
        v0 = 1'b1; rr = 1'b0; d0 = rand128(); k0 = rand128();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc0) begin cnt++; d0 = rand128(); k0 = rand128(); end
        end
        check_val("t5_accepts", 128'(cnt), 128'(5));
        v0 = 1'b1; v1 = 1'b1;
        do_reset();
        rr = 1'b1;
        repeat (20) step();
        v0 = 1'b1; v1 = 1'b1;
        d0 = rand128(); k0 = rand128(); d1 = rand128(); k1 = rand128();
        step();
        check_val("t5_first_grant", 128'(acc0), 128'(1));
        v0 = 1'b0; v1 = 1'b0;
        repeat (20) step();

        // T6: random traffic on all interfaces
        blocks = 0; cyc = 0;
        while (blocks < 10000 && cyc < 40000) begin
            if (!v0 && $urandom_range(0, 3) != 0) begin v0 = 1'b1; d0 = rand128(); k0 = rand128(); end
            if (!v1 && $urandom_range(0, 3) != 0) begin v1 = 1'b1; d1 = rand128(); k1 = rand128(); end
            rr = $urandom_range(0, 3) != 0;
            step();
            cyc++;
            if (acc0) begin v0 = 1'b0; blocks++; end
            if (acc1) begin v1 = 1'b0; blocks++; end
        end
        check_val("t6_blocks", 128'(blocks), 128'(10000));
        v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
        repeat (60) step();
        check_val("t6_drained", 128'(inflight), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
